// File: rtl/duck_round_ctrl.sv
// Round sequencer for the duck game: idle, ready pause, flight, result pause.
// Tracks ammo, hits, hit bitmap and saturating score for the HUD.
module duck_round_ctrl #(
    parameter int DUCKS_PER_ROUND = 10,
    parameter int SHOTS           = 3,
    parameter int READY_FRAMES    = 60,
    parameter int FLY_FRAMES      = 300,
    parameter int RESULT_FRAMES   = 90,
    parameter int POINTS          = 500
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       frame_clk,
    input  logic                       start,
    input  logic                       trigger,
    input  logic                       bird_shot,
    input  logic                       flew_away,
    output logic [1:0]                 state,
    output logic                       new_duck,
    output logic [1:0]                 shots_left,
    output logic [3:0]                 duck_idx,
    output logic [3:0]                 hits,
    output logic [DUCKS_PER_ROUND-1:0] hit_map,
    output logic                       last_hit,
    output logic [15:0]                score,
    output logic                       round_done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_READY  = 2'b01,
        S_FLY    = 2'b10,
        S_RESULT = 2'b11
    } state_t;

    localparam logic [8:0] C_READY  = 9'(READY_FRAMES - 1);
    localparam logic [8:0] C_FLY    = 9'(FLY_FRAMES - 1);
    localparam logic [8:0] C_RESULT = 9'(RESULT_FRAMES - 1);
    localparam logic [3:0] C_LAST   = 4'(DUCKS_PER_ROUND - 1);

    state_t                     r_state;
    logic                       r_fclk_d;
    logic [8:0]                 r_tick_cnt;
    logic                       r_out_of_ammo;
    logic                       r_new_duck;
    logic [1:0]                 r_shots;
    logic [3:0]                 r_duck_idx;
    logic [3:0]                 r_hits;
    logic [DUCKS_PER_ROUND-1:0] r_hit_map;
    logic                       r_last_hit;
    logic [15:0]                r_score;
    logic                       r_round_done;

    state_t                     w_state_nxt;
    logic                       w_tick;
    logic                       w_state_chg;
    logic [16:0]                w_sum;
    logic [8:0]                 w_tick_cnt_nxt;
    logic                       w_ooa_nxt;
    logic                       w_new_duck_nxt;
    logic [1:0]                 w_shots_nxt;
    logic [3:0]                 w_duck_idx_nxt;
    logic [3:0]                 w_hits_nxt;
    logic [DUCKS_PER_ROUND-1:0] w_hit_map_nxt;
    logic                       w_last_hit_nxt;
    logic [15:0]                w_score_nxt;
    logic                       w_round_done_nxt;

    assign w_tick      = frame_clk & ~r_fclk_d;
    assign w_state_chg = (w_state_nxt != r_state);
    assign w_sum       = {1'b0, r_score} + 17'(POINTS);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_READY;
            end
            S_READY: begin
                if (w_tick && r_tick_cnt == C_READY) w_state_nxt = S_FLY;
            end
            S_FLY: begin
                // Ammo-out waits one frame tick so a final-shot hit can still land
                if (bird_shot || flew_away ||
                    (w_tick && (r_tick_cnt == C_FLY || r_out_of_ammo)))
                    w_state_nxt = S_RESULT;
            end
            S_RESULT: begin
                if (w_tick && r_tick_cnt == C_RESULT)
                    w_state_nxt = (r_duck_idx == C_LAST) ? S_IDLE : S_READY;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_tick_cnt_nxt   = r_tick_cnt;
        w_ooa_nxt        = r_out_of_ammo;
        w_new_duck_nxt   = 1'b0;
        w_shots_nxt      = r_shots;
        w_duck_idx_nxt   = r_duck_idx;
        w_hits_nxt       = r_hits;
        w_hit_map_nxt    = r_hit_map;
        w_last_hit_nxt   = r_last_hit;
        w_score_nxt      = r_score;
        w_round_done_nxt = 1'b0;

        if (r_state == S_IDLE || w_state_chg) w_tick_cnt_nxt = '0;
        else if (w_tick)                      w_tick_cnt_nxt = r_tick_cnt + 9'd1;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_duck_idx_nxt = '0;
                    w_hits_nxt     = '0;
                    w_hit_map_nxt  = '0;
                    w_last_hit_nxt = 1'b0;
                    w_score_nxt    = '0;
                end
            end
            S_READY: begin
                if (w_state_chg) begin
                    w_shots_nxt    = 2'(SHOTS);
                    w_new_duck_nxt = 1'b1;
                    w_ooa_nxt      = 1'b0;
                end
            end
            S_FLY: begin
                if (trigger && r_shots != 2'd0) begin
                    w_shots_nxt = r_shots - 2'd1;
                    if (r_shots == 2'd1) w_ooa_nxt = 1'b1;
                end
                if (bird_shot) begin
                    w_hits_nxt     = r_hits + 4'd1;
                    w_last_hit_nxt = 1'b1;
                    w_score_nxt    = w_sum[16] ? 16'hFFFF : w_sum[15:0];
                    for (int i = 0; i < DUCKS_PER_ROUND; i++)
                        if (r_duck_idx == 4'(i)) w_hit_map_nxt[i] = 1'b1;
                end else if (w_state_chg) begin
                    w_last_hit_nxt = 1'b0;
                end
            end
            S_RESULT: begin
                if (w_state_chg) begin
                    if (r_duck_idx == C_LAST) w_round_done_nxt = 1'b1;
                    else                      w_duck_idx_nxt   = r_duck_idx + 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_fclk_d      <= 1'b0;
            r_tick_cnt    <= '0;
            r_out_of_ammo <= 1'b0;
            r_new_duck    <= 1'b0;
            r_shots       <= '0;
            r_duck_idx    <= '0;
            r_hits        <= '0;
            r_hit_map     <= '0;
            r_last_hit    <= 1'b0;
            r_score       <= '0;
            r_round_done  <= 1'b0;
        end else begin
            r_fclk_d      <= frame_clk;
            r_tick_cnt    <= w_tick_cnt_nxt;
            r_out_of_ammo <= w_ooa_nxt;
            r_new_duck    <= w_new_duck_nxt;
            r_shots       <= w_shots_nxt;
            r_duck_idx    <= w_duck_idx_nxt;
            r_hits        <= w_hits_nxt;
            r_hit_map     <= w_hit_map_nxt;
            r_last_hit    <= w_last_hit_nxt;
            r_score       <= w_score_nxt;
            r_round_done  <= w_round_done_nxt;
        end
    end

    assign state      = r_state;
    assign new_duck   = r_new_duck;
    assign shots_left = r_shots;
    assign duck_idx   = r_duck_idx;
    assign hits       = r_hits;
    assign hit_map    = r_hit_map;
    assign last_hit   = r_last_hit;
    assign score      = r_score;
    assign round_done = r_round_done;

endmodule

// File: tb/tb_duck_round_ctrl.sv
// Directed bench for duck_round_ctrl with 3 ducks, 3 shots,
// 2 ready ticks, 5 fly ticks and 2 result ticks.
module tb_duck_round_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic        start = 1'b0;
    logic        trigger = 1'b0;
    logic        bird_shot = 1'b0;
    logic        flew_away = 1'b0;
    logic [1:0]  state;
    logic        new_duck;
    logic [1:0]  shots_left;
    logic [3:0]  duck_idx;
    logic [3:0]  hits;
    logic [2:0]  hit_map;
    logic        last_hit;
    logic [15:0] score;
    logic        round_done;

    int n_checks = 0;
    int n_fail   = 0;

    duck_round_ctrl #(
        .DUCKS_PER_ROUND(3),
        .SHOTS(3),
        .READY_FRAMES(2),
        .FLY_FRAMES(5),
        .RESULT_FRAMES(2),
        .POINTS(500)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .frame_clk(frame_clk),
        .start(start),
        .trigger(trigger),
        .bird_shot(bird_shot),
        .flew_away(flew_away),
        .state(state),
        .new_duck(new_duck),
        .shots_left(shots_left),
        .duck_idx(duck_idx),
        .hits(hits),
        .hit_map(hit_map),
        .last_hit(last_hit),
        .score(score),
        .round_done(round_done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk) frame_clk = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic p_start();
        @(negedge Clk) start = 1'b1;
        @(negedge Clk) start = 1'b0;
    endtask

    task automatic p_trig();
        @(negedge Clk) trigger = 1'b1;
        @(negedge Clk) trigger = 1'b0;
    endtask

    task automatic p_shot();
        @(negedge Clk) bird_shot = 1'b1;
        @(negedge Clk) bird_shot = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_st"}, 32'(state), 32'd0);
        chk({tag, "_nd"}, 32'(new_duck), 32'd0);
        chk({tag, "_sh"}, 32'(shots_left), 32'd0);
        chk({tag, "_ix"}, 32'(duck_idx), 32'd0);
        chk({tag, "_hi"}, 32'(hits), 32'd0);
        chk({tag, "_hm"}, 32'(hit_map), 32'd0);
        chk({tag, "_lh"}, 32'(last_hit), 32'd0);
        chk({tag, "_sc"}, 32'(score), 32'd0);
        chk({tag, "_rd"}, 32'(round_done), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        check_zero("rst");
        Reset = 1'b0;
        @(negedge Clk);
        chk("idle_trig_st", 32'(state), 32'd0);

        // Round A: hit, ammo-out miss, simultaneous hit/escape
        p_start();
        chk("a_ready", 32'(state), 32'd1);
        tick();
        chk("a_ready1", 32'(state), 32'd1);
        tick();
        chk("a_fly", 32'(state), 32'd2);
        chk("a_nd_hi", 32'(new_duck), 32'd1);
        chk("a_shots3", 32'(shots_left), 32'd3);
        @(negedge Clk);
        chk("a_nd_lo", 32'(new_duck), 32'd0);
        p_start();
        chk("a_start_ign", 32'(state), 32'd2);
        p_shot();
        chk("a_hit_st", 32'(state), 32'd3);
        chk("a_hits1", 32'(hits), 32'd1);
        chk("a_map1", 32'(hit_map), 32'd1);
        chk("a_score1", 32'(score), 32'd500);
        chk("a_lh1", 32'(last_hit), 32'd1);
        p_trig();
        chk("a_res_trig", 32'(shots_left), 32'd3);
        ticks(2);
        chk("a_ready_d1", 32'(state), 32'd1);
        chk("a_idx1", 32'(duck_idx), 32'd1);
        ticks(2);
        chk("a_fly_d1", 32'(state), 32'd2);
        p_trig();
        chk("a_sh2", 32'(shots_left), 32'd2);
        p_trig();
        chk("a_sh1", 32'(shots_left), 32'd1);
        p_trig();
        chk("a_sh0", 32'(shots_left), 32'd0);
        chk("a_grace", 32'(state), 32'd2);
        p_trig();
        chk("a_sh0_hold", 32'(shots_left), 32'd0);
        tick();
        chk("a_ammo_res", 32'(state), 32'd3);
        chk("a_ammo_lh", 32'(last_hit), 32'd0);
        chk("a_ammo_sc", 32'(score), 32'd500);
        ticks(4);
        chk("a_fly_d2", 32'(state), 32'd2);
        chk("a_idx2", 32'(duck_idx), 32'd2);
        @(negedge Clk) begin
            bird_shot = 1'b1;
            flew_away = 1'b1;
        end
        @(negedge Clk) begin
            bird_shot = 1'b0;
            flew_away = 1'b0;
        end
        chk("a_both_st", 32'(state), 32'd3);
        chk("a_both_hits", 32'(hits), 32'd2);
        chk("a_both_sc", 32'(score), 32'd1000);
        chk("a_both_lh", 32'(last_hit), 32'd1);
        tick();
        chk("a_rd_pre", 32'(round_done), 32'd0);
        tick();
        chk("a_rd", 32'(round_done), 32'd1);
        chk("a_idle", 32'(state), 32'd0);
        @(negedge Clk);
        chk("a_rd_lo", 32'(round_done), 32'd0);
        chk("a_map_end", 32'(hit_map), 32'd5);

        // Round B: hit, timeout miss, hit
        p_start();
        chk("b_clr_sc", 32'(score), 32'd0);
        chk("b_clr_hits", 32'(hits), 32'd0);
        chk("b_clr_idx", 32'(duck_idx), 32'd0);
        ticks(2);
        p_shot();
        ticks(4);
        chk("b_fly_d1", 32'(state), 32'd2);
        ticks(4);
        chk("b_to_pre", 32'(state), 32'd2);
        tick();
        chk("b_to_st", 32'(state), 32'd3);
        chk("b_to_lh", 32'(last_hit), 32'd0);
        ticks(4);
        p_shot();
        ticks(2);
        chk("b_rd", 32'(round_done), 32'd1);
        chk("b_idle", 32'(state), 32'd0);
        chk("b_hits", 32'(hits), 32'd2);
        chk("b_map", 32'(hit_map), 32'd5);
        chk("b_score", 32'(score), 32'd1000);

        // Round C: reset while flying
        p_start();
        ticks(2);
        p_shot();
        ticks(4);
        p_trig();
        chk("c_fly", 32'(state), 32'd2);
        chk("c_sh2", 32'(shots_left), 32'd2);
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1 check_zero("crst_async");
        @(negedge Clk);
        check_zero("crst_hold");
        Reset = 1'b0;
        @(negedge Clk);
        chk("c_post_st", 32'(state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
